// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the read-bypass select for the register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // Read-data source, in priority order: zero reg, port A, port B, storage.
  typedef enum logic [1:0] {
    SEL_STORE = 2'd0,
    SEL_WA    = 2'd1,
    SEL_WB    = 2'd2,
    SEL_ZERO  = 2'd3
  } rd_sel_e;

  // Bypass priority mirrors write priority, so a read sees the value that will commit.
  function automatic rd_sel_e bypass_sel(input logic is_zero, input logic hit_a,
                                         input logic hit_b);
    if (is_zero)    return SEL_ZERO;
    else if (hit_a) return SEL_WA;
    else if (hit_b) return SEL_WB;
    else            return SEL_STORE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard with write-collision detection.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int NUM_RD   = DEF_NUM_RD
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o,
  output logic                     collision_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             collision_d;

  // Next busy bits: a new issue sets, a write retires, otherwise hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid_i && (iss_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wa_en_i && (wa_addr_i == ADDR_W'(i))) ||
                   (wb_en_i && (wb_addr_i == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Two ports writing the same architected register; writes to r0 are discarded so never collide.
  always_comb begin
    collision_d = wa_en_i && wb_en_i && (wa_addr_i == wb_addr_i) &&
                  !((ZERO_REG != 0) && (wa_addr_i == '0));
  end

  // Scoreboard and collision flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q      <= '0;
      collision_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      busy_q      <= busy_d;
      collision_o <= collision_d;
    end
  end

  assign busy_vec_o = busy_q;

  // Per-port busy lookup; a same-cycle write bypasses its data, so no stall is reported.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign rd_busy_o[k] = busy_q[addr] &
                          ~((wa_en_i && (wa_addr_i == addr)) ||
                            (wb_en_i && (wb_addr_i == addr)));
  end

endmodule

// File: rtl/param_regfile_sb.sv
// Parametrised CPU register file: two write ports, bypassed reads, pending-write scoreboard.
module param_regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  output logic [(1<<ADDR_W)-1:0]   busy_vec_o,
  output logic                     collision_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wa_ok;
  logic              wb_ok;

  assign wa_ok = wa_en_i && !((ZERO_REG != 0) && (wa_addr_i == '0));
  assign wb_ok = wb_en_i && !((ZERO_REG != 0) && (wb_addr_i == '0));

  // Register storage; port B commits first so port A's later assignment wins on a shared address.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the array is cleared on reset because software relies on all registers reading 0.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (wb_ok) regs_q[wb_addr_i] <= wb_data_i;
      if (wa_ok) regs_q[wa_addr_i] <= wa_data_i;
    end
  end

  // Read ports with same-cycle write bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    rd_sel_e           sel;
    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

    always_comb begin
      sel = bypass_sel((ZERO_REG != 0) && (addr == '0),
                       wa_en_i && (wa_addr_i == addr),
                       wb_en_i && (wb_addr_i == addr));
      unique case (sel)
        SEL_ZERO: rd_data_o[k*DATA_W +: DATA_W] = '0;
        SEL_WA:   rd_data_o[k*DATA_W +: DATA_W] = wa_data_i;
        SEL_WB:   rd_data_o[k*DATA_W +: DATA_W] = wb_data_i;
        default:  rd_data_o[k*DATA_W +: DATA_W] = regs_q[addr];
      endcase
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .iss_valid_i (iss_valid_i),
    .iss_addr_i  (iss_addr_i),
    .wa_en_i     (wa_en_i),
    .wa_addr_i   (wa_addr_i),
    .wb_en_i     (wb_en_i),
    .wb_addr_i   (wb_addr_i),
    .rd_addr_i   (rd_addr_i),
    .rd_busy_o   (rd_busy_o),
    .busy_vec_o  (busy_vec_o),
    .collision_o (collision_o)
  );

endmodule

// File: tb/tb_param_regfile_sb.sv
// Directed bench for param_regfile_sb: default build, ZERO_REG=0 build and a 64x64 three-port build.
module tb_param_regfile_sb;

  logic clk;
  logic rst_n;

  // Stimulus shared by the two 32-bit builds.
  logic [9:0]  rd_addr;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  // ZERO_REG=1 build outputs.
  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic [31:0] busy_vec0;
  logic        coll0;

  // ZERO_REG=0 build outputs.
  logic [63:0] rd_data1;
  logic [1:0]  rd_busy1;
  logic [31:0] busy_vec1;
  logic        coll1;

  // Wide build.
  logic [17:0]  rd_addr2;
  logic [191:0] rd_data2;
  logic [2:0]   rd_busy2;
  logic         iss_valid2;
  logic [5:0]   iss_addr2;
  logic         wa_en2;
  logic [5:0]   wa_addr2;
  logic [63:0]  wa_data2;
  logic         wb_en2;
  logic [5:0]   wb_addr2;
  logic [63:0]  wb_data2;
  logic [63:0]  busy_vec2;
  logic         coll2;

  int checks = 0;
  int errors = 0;

  param_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_z1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_vec_o(busy_vec0), .collision_o(coll0)
  );

  param_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_z0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_vec_o(busy_vec1), .collision_o(coll1)
  );

  param_regfile_sb #(.DATA_W(64), .ADDR_W(6), .NUM_RD(3), .ZERO_REG(1)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_addr_i(rd_addr2), .rd_data_o(rd_data2), .rd_busy_o(rd_busy2),
    .iss_valid_i(iss_valid2), .iss_addr_i(iss_addr2),
    .wa_en_i(wa_en2), .wa_addr_i(wa_addr2), .wa_data_i(wa_data2),
    .wb_en_i(wb_en2), .wb_addr_i(wb_addr2), .wb_data_i(wb_data2),
    .busy_vec_o(busy_vec2), .collision_o(coll2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid  = 1'b0; iss_addr  = '0;
    wa_en      = 1'b0; wa_addr   = '0; wa_data  = '0;
    wb_en      = 1'b0; wb_addr   = '0; wb_data  = '0;
    iss_valid2 = 1'b0; iss_addr2 = '0;
    wa_en2     = 1'b0; wa_addr2  = '0; wa_data2 = '0;
    wb_en2     = 1'b0; wb_addr2  = '0; wb_data2 = '0;
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    rd_addr2 = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // Reset state.
    rd_addr = {5'd0, 5'd5};
    #1;
    check("reset_r5", 64'(rd_data0[31:0]), 64'h0);
    check("reset_busy_vec", 64'(busy_vec0), 64'h0);
    check("reset_collision", 64'(coll0), 64'h0);
    check("reset_busy_vec_wide", busy_vec2, 64'h0);

    // Write r5 on both ports (A wins), issue r7, then reset asynchronously mid-run.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h00000000;
    iss_valid = 1'b1; iss_addr = 5'd7;
    step();
    idle();
    #1;
    check("pre_reset_r5", 64'(rd_data0[31:0]), 64'hDEADBEEF);
    check("pre_reset_busy_vec", 64'(busy_vec0), 64'h80);
    check("pre_reset_collision", 64'(coll0), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_r5", 64'(rd_data0[31:0]), 64'h0);
    check("async_reset_busy_vec", 64'(busy_vec0), 64'h0);
    check("async_reset_collision", 64'(coll0), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // Write r3 with same-cycle bypass; r4 untouched.
    rd_addr = {5'd4, 5'd3};
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h12345678;
    #1;
    check("bypass_r3", 64'(rd_data0[31:0]), 64'h12345678);
    check("read_r4", 64'(rd_data0[63:32]), 64'h0);
    step();
    idle();
    #1;
    check("stored_r3", 64'(rd_data0[31:0]), 64'h12345678);

    // Dual write to r9: port A wins, one-cycle collision pulse.
    rd_addr = {5'd0, 5'd9};
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hAAAA0000;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555FFFF;
    #1;
    check("collide_bypass_r9", 64'(rd_data0[31:0]), 64'hAAAA0000);
    check("collision_before", 64'(coll0), 64'h0);
    step();
    idle();
    #1;
    check("collide_stored_r9", 64'(rd_data0[31:0]), 64'hAAAA0000);
    check("collision_pulse", 64'(coll0), 64'h1);
    step();
    check("collision_cleared", 64'(coll0), 64'h0);

    // Scoreboard: issue r10 at t, retire by port B at t+3.
    rd_addr = {5'd0, 5'd10};
    iss_valid = 1'b1; iss_addr = 5'd10;
    #1;
    check("busy_not_yet_t", 64'(rd_busy0[0]), 64'h0);
    step();                                  // t+1
    idle();
    #1;
    check("busy_t1", 64'(rd_busy0[0]), 64'h1);
    check("busy_vec10_t1", 64'(busy_vec0[10]), 64'h1);
    step();                                  // t+2
    check("busy_t2", 64'(rd_busy0[0]), 64'h1);
    step();                                  // t+3
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0BADF00D;
    #1;
    check("busy_bypassed_t3", 64'(rd_busy0[0]), 64'h0);
    check("data_bypassed_t3", 64'(rd_data0[31:0]), 64'h0BADF00D);
    check("busy_vec10_t3", 64'(busy_vec0[10]), 64'h1);
    step();                                  // t+4
    idle();
    #1;
    check("busy_vec10_t4", 64'(busy_vec0[10]), 64'h0);
    check("busy_t4", 64'(rd_busy0[0]), 64'h0);

    // Issue and write to r10 in the same cycle: the new producer keeps it busy.
    iss_valid = 1'b1; iss_addr = 5'd10;
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'h00000042;
    step();
    idle();
    #1;
    check("issue_beats_write", 64'(busy_vec0[10]), 64'h1);
    check("issue_beats_write_rd", 64'(rd_busy0[0]), 64'h1);

    // Register 0 on both builds.
    rd_addr = {5'd0, 5'd0};
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h11111111;
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1;
    check("z1_r0_bypass", 64'(rd_data0[31:0]), 64'h0);
    check("z1_r0_rd_busy", 64'(rd_busy0[0]), 64'h0);
    check("z0_r0_bypass", 64'(rd_data1[31:0]), 64'hFFFFFFFF);
    step();
    idle();
    #1;
    check("z1_r0_stored", 64'(rd_data0[31:0]), 64'h0);
    check("z1_busy_vec0", 64'(busy_vec0[0]), 64'h0);
    check("z1_no_collision", 64'(coll0), 64'h0);
    check("z0_r0_stored", 64'(rd_data1[31:0]), 64'hFFFFFFFF);
    check("z0_busy_vec0", 64'(busy_vec1[0]), 64'h1);
    check("z0_collision", 64'(coll1), 64'h1);

    // Wide build: r63 on all three ports, then busy bits 32 and 63.
    rd_addr2 = {6'd63, 6'd63, 6'd63};
    wa_en2 = 1'b1; wa_addr2 = 6'd63; wa_data2 = 64'h0123456789ABCDEF;
    #1;
    check("wide_bypass_p0", rd_data2[63:0], 64'h0123456789ABCDEF);
    check("wide_bypass_p1", rd_data2[127:64], 64'h0123456789ABCDEF);
    check("wide_bypass_p2", rd_data2[191:128], 64'h0123456789ABCDEF);
    step();
    idle();
    #1;
    check("wide_stored_p0", rd_data2[63:0], 64'h0123456789ABCDEF);
    check("wide_stored_p1", rd_data2[127:64], 64'h0123456789ABCDEF);
    check("wide_stored_p2", rd_data2[191:128], 64'h0123456789ABCDEF);
    iss_valid2 = 1'b1; iss_addr2 = 6'd32;
    step();
    iss_valid2 = 1'b1; iss_addr2 = 6'd63;
    step();
    idle();
    #1;
    check("wide_busy_vec", busy_vec2, 64'h8000000100000000);
    check("wide_rd_busy", 64'(rd_busy2), 64'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_regfile_sb.md
Name: param_regfile_sb

Overview:
- Next-generation CPU register file: parametrised width, depth and read-port count; two write ports (A: ALU writeback, B: memory/load writeback).
- Keeps same-cycle write-to-read bypass and hardwired zero register.
- Adds an integrated per-register pending-write scoreboard, so the decode stage can detect RAW hazards before operands are used.
- Sits between decode (reads, issue) and writeback (two write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  asynchronous active-low reset
rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data, combinational, port k at [k*DATA_W +: DATA_W]
rd_busy_o  out  NUM_RD  1 = addressed register has an outstanding producer
iss_valid_i  in  1  issue strobe: mark iss_addr_i pending
iss_addr_i  in  ADDR_W  destination of issued instruction
wa_en_i  in  1  write port A enable
wa_addr_i  in  ADDR_W  write port A address
wa_data_i  in  DATA_W  write port A data
wb_en_i  in  1  write port B enable
wb_addr_i  in  ADDR_W  write port B address
wb_data_i  in  DATA_W  write port B data
busy_vec_o  out  2**ADDR_W  registered scoreboard bit vector
collision_o  out  1  registered pulse: previous cycle had A and B writing same address

Behaviour:
- Reset (rst_n_i low, asynchronous): all registers = 0, all busy bits = 0, collision_o = 0. Held while low; writes/issues ignored. Deassertion mid-operation: no pending state survives.
- Write: on rising edge, register[wa_addr_i] <= wa_data_i if wa_en_i; register[wb_addr_i] <= wb_data_i if wb_en_i. Different addresses: both commit. Same address: port A wins; collision_o = 1 for exactly the following cycle, else 0.
- Read (zero latency, combinational per port): if rd_addr == wa_addr_i and wa_en_i -> wa_data_i; else if rd_addr == wb_addr_i and wb_en_i -> wb_data_i; else stored value. Bypass priority matches write priority.
- Scoreboard per register:
  - Next busy = 1 if iss_valid_i targets it.
  - Else 0 if either write port enables at it.
  - Else hold.
- Issue and write to the same address in one cycle: busy stays set, because a new producer supersedes.
- rd_busy_o[k] = busy[addr] AND NOT (write enabled to addr this cycle). Data is bypassed, so no stall is reported. Issue in the current cycle affects rd_busy_o only from the next cycle.
- ZERO_REG=1, address 0:
  - Reads return 0, including when a write to it is bypassed.
  - Writes are discarded.
  - Issue is ignored.
  - busy[0] is constant 0.
  - No collision_o for two writes to 0.
- ZERO_REG=0: register 0 behaves as an ordinary register.
- busy_vec_o reflects registered busy bits only (no bypass).
- No X on outputs for any in-range address; all addresses are in range by construction.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - reg_addr_t and reg_data_t typedefs;
  - a function computing the bypass-priority select.
- Sub-module regfile_scoreboard (ADDR_W, ZERO_REG) contains:
  - busy bit array, set/clear priority, busy_vec_o and collision_o logic;
  - a per-address busy lookup for the read-port instances.
- Top holds the storage array, write logic and the NUM_RD read/bypass generate loop.

Test Plan:
1. Reset check: pulse rst_n_i low mid-run after writing 0xDEADBEEF to r5 and issuing r7 -> immediately rd_data of r5 = 0, busy_vec_o = 0, collision_o = 0.
2. Write/read with bypass: wa writes r3 = 0x12345678.
   - Same cycle, read port 0 at r3 returns 0x12345678.
   - Next cycle, with no write, it returns 0x12345678 from storage.
   - r4 reads 0.
3. Dual-write collision: wa r9 = 0xAAAA0000 and wb r9 = 0x5555FFFF in the same cycle.
   - Same-cycle read = 0xAAAA0000; next-cycle read = 0xAAAA0000.
   - collision_o = 1 for one cycle, then 0.
4. Scoreboard:
   - Issue r10 at cycle t -> rd_busy_o = 1 from t+1.
   - wb writes r10 at t+3 -> rd_busy_o = 0 in t+3 (bypass) and busy_vec_o[10] = 0 from t+4.
   - Issue r10 and wa write r10 in the same cycle -> busy remains 1.
5. Zero register (ZERO_REG=1): wa writes r0 = 0xFFFFFFFF and issue r0 -> rd_data = 0, rd_busy_o = 0, busy_vec_o[0] = 0. Repeat with ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
6. Parametrised build DATA_W=64, ADDR_W=6, NUM_RD=3:
   - Writes to r63 = 0x0123456789ABCDEF read back on all three ports simultaneously.
   - Issues to r32 and r63 set exactly busy_vec_o bits 32 and 63.
